rvm_mem_arbiter: RTL and testbench
==================================

# rvm_mem_arbiter

Shares the core's single memory port between the instruction-fetch requester and the load/store requester of the control FSM. Each requester sees a simple req/ack port. The arbiter selects one requester, registers its request, and drives the memory bus until the transfer completes. It then returns registered read data and error status to the winner, and aborts any transfer the memory stalls for too long. It sits between `rvm_control` and the top-level `mem_*` pins.

## Interface
- `TIMEOUT_W`, default 8: width of the stall-timeout counter. A transfer aborts after 2^TIMEOUT_W-1 consecutive stalled cycles.
- `clk` in 1: system clock. All state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request. Held high until `f_ack`.
- `f_addr` in 32: fetch address.
- `f_ack` out 1: one-cycle pulse; fetch transfer finished.
- `f_rdata` out 32: fetch read data. Valid with `f_ack`, held until the next `f_ack`.
- `f_error` out 1: fetch error. Valid with `f_ack`, held until the next `f_ack`.
- `d_req` in 1: load/store request. Held high until `d_ack`.
- `d_addr` in 32: load/store address.
- `d_wdata` in 32: store data.
- `d_b_en` in 4: load/store byte enables.
- `d_w_en` in 1: 1 = store, 0 = load.
- `d_ack`, `d_rdata`, `d_error`: as for the fetch port, applied to the load/store port.
- `mem_addr` out 32: memory address (registered).
- `mem_wdata` out 32: memory write data (registered).
- `mem_c_en` out 1: memory chip enable.
- `mem_b_en` out 4: memory byte enables (registered).
- `mem_w_en` out 1: memory write enable (registered).
- `mem_rdata` in 32: memory read data, sampled in the completing cycle.
- `mem_error` in 1: memory error, sampled in the completing cycle.
- `mem_stall` in 1: memory not ready. The current cycle does not complete.
- `arb_busy` out 1: a transfer is in flight (state is not IDLE).

## Operation
- State machine: IDLE, BUSY_F, BUSY_D. Encoding is 2 bits, with IDLE = 0.
- **IDLE:** the effective requests are `f_req & !f_ack` and `d_req & !d_ack`. A requester's `req` is masked in the cycle its ack is high, so the request that was just served is never re-granted.
  - If exactly one request is effective, grant it.
  - If both are effective, apply the tie rule (see Configuration).
  - On grant, register the address, wdata, b_en and w_en, then move to BUSY_F or BUSY_D.
  - A fetch grant always loads `mem_w_en` = 0, `mem_b_en` = 4'b1111 and `mem_wdata` = 0.
- **BUSY_x:** `mem_c_en` = 1 and the registered bus signals are held stable.
  - If `mem_stall` = 0, the cycle completes: register `mem_rdata` into `x_rdata` and `mem_error` into `x_error`, pulse `x_ack` in the next cycle, and return to IDLE.
  - If `mem_stall` = 1, increment the stall counter. When the counter reaches 2^TIMEOUT_W-1 with stall still high, abort: `x_rdata` = 0, `x_error` = 1, `x_ack` pulses, and the state returns to IDLE.
  - The stall counter clears on every grant.
- Store completions return `x_rdata` = `mem_rdata` as sampled. The requester ignores it.
- The request inputs are not sampled during BUSY. Changing them mid-transfer has no effect.
- **Async reset mid-transfer:** `mem_c_en` drops at once and the transfer is abandoned without an ack. The requester re-issues after reset.
- Reset values: state IDLE; `mem_addr`, `mem_wdata`, `mem_b_en`, `mem_w_en` = 0; `mem_c_en` = 0; both acks = 0; both rdata = 0; both error = 0; `arb_busy` = 0; stall counter = 0; last-grant register = DATA.

## Timing
- Grant latency: a request in IDLE at cycle N produces `mem_c_en` high at cycle N+1.
- Unstalled transfer: completes at N+1; ack and rdata appear at N+2. Three cycles from request to ack.
- Each stalled cycle adds one cycle.
- Ack cycle: the state is IDLE and the other requester may be granted in that same cycle. This gives back-to-back transfers with one idle memory cycle between them.
- `mem_c_en` is decoded from state only. There is no combinational path from `mem_*` inputs to `mem_*` outputs.
- `mem_rdata` and `mem_error` are only sampled when `mem_c_en` = 1 and `mem_stall` = 0.

## Configuration
- `RVM_MEM_ARB_RR_EN` defined: round-robin on ties.
  - The last-grant register records the winner of each grant.
  - On a tie, the requester not granted last wins.
  - The first tie after reset goes to fetch.
- `RVM_MEM_ARB_RR_EN` undefined: fixed priority, data always wins a tie.
  - The last-grant register is not implemented.

## Test plan
- **Single fetch:** `f_req` = 1, `f_addr` = 0x100, no stall, `mem_rdata` = 0x00000013 -> `mem_c_en` high for exactly 1 cycle with `mem_addr` = 0x100 and `mem_w_en` = 0; `f_ack` pulses 2 cycles after `f_req` with `f_rdata` = 0x13 and `f_error` = 0.
- **Stalled store:** `d_req`, `d_w_en` = 1, `d_addr` = 0x2000, `d_wdata` = 0xDEADBEEF, `d_b_en` = 4'b0011, `mem_stall` high for 3 cycles -> bus signals stable for 4 cycles; `d_ack` pulses once, 1 cycle after stall falls.
- **Simultaneous requests, held for 4 transfers:**
  - With `RVM_MEM_ARB_RR_EN`: grant order F, D, F, D.
  - Without it: data wins every tie.
  - Ack cycles never re-grant the same requester.
- **Timeout, `TIMEOUT_W` = 4:** stall held high -> abort after 15 stalled cycles; `x_ack` = 1, `x_error` = 1, `x_rdata` = 0; state IDLE.
- **Error pass-through:** `mem_error` = 1 in the completing cycle of a load -> `d_error` = 1 with `d_ack`; it stays 1 until the next `d_ack`.
- **Reset mid-transfer:** `resetn` low during a stalled BUSY_D -> `mem_c_en` = 0 immediately; no ack; all outputs at their reset values; after release, a new `f_req` completes normally.

Source files
------------

// File: rtl/rvm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_arbiter
// Purpose  : Shares the single memory port between the instruction-fetch
//            requester (f_*) and the load/store requester (d_*). One
//            requester wins, its request is registered onto the mem_* bus,
//            and the bus is held until the memory completes the cycle or the
//            stall timeout aborts it. Read data and error status come back
//            registered, together with a one-cycle ack.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   f_req/f_addr           : fetch request (held until f_ack)
//   f_ack/f_rdata/f_error  : fetch completion pulse, data, error
//   d_req/d_addr/d_wdata   : load/store request, address, store data
//   d_b_en/d_w_en          : byte enables, 1 = store
//   d_ack/d_rdata/d_error  : load/store completion pulse, data, error
//   mem_addr/mem_wdata     : registered memory address / write data
//   mem_b_en/mem_w_en      : registered byte enables / write enable
//   mem_c_en               : chip enable, decoded from state
//   mem_rdata/mem_error    : memory response, sampled on completion
//   mem_stall              : memory not ready this cycle
//   arb_busy               : a transfer is in flight
// Parameters
//   TIMEOUT_W              : stall counter width; abort after
//                            2^TIMEOUT_W-1 consecutive stalled cycles
// Configuration macro
//   RVM_MEM_ARB_RR_EN      : defined -> round-robin on ties (first tie goes
//                            to fetch); undefined -> data always wins ties
// ============================================================================
module rvm_mem_arbiter #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch port
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_error,
  // load/store port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_b_en,
  input  logic        d_w_en,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_error,
  // memory bus
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic [3:0]  mem_b_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  input  logic        mem_stall,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // Counter value seen in the stalled cycle that makes it the last allowed
  // one: the transfer aborts at the end of stalled cycle number 2^W-1.
  localparam logic [TIMEOUT_W-1:0] C_ABORT_CNT = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic [TIMEOUT_W-1:0] r_stall_cnt;

  logic w_f_eff;
  logic w_d_eff;
  logic w_tie_f;
  logic w_grant_f;
  logic w_grant_d;
  logic w_complete;
  logic w_abort;
  logic w_done_f;
  logic w_done_d;

  // A requester still holds req during its ack cycle; masking it there keeps
  // the transfer that just finished from being granted a second time.
  assign w_f_eff = f_req & ~f_ack;
  assign w_d_eff = d_req & ~d_ack;

`ifdef RVM_MEM_ARB_RR_EN
  // 1 = data won the most recent grant. Resets to data so the first tie
  // goes to fetch.
  logic r_last_d;

  assign w_tie_f = ~r_last_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_d <= 1'b1;
    end else if (w_grant_f) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end
  end
`else
  assign w_tie_f = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / grant / completion decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_grant_f    = 1'b0;
    w_grant_d    = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_f_eff && (!w_d_eff || w_tie_f)) begin
          w_grant_f    = 1'b1;
          w_next_state = BUSY_F;
        end else if (w_d_eff) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end
      end
      BUSY_F, BUSY_D: begin
        if (!mem_stall) begin
          w_complete   = 1'b1;
          w_next_state = IDLE;
        end else if (r_stall_cnt == C_ABORT_CNT) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_done_f = (w_complete | w_abort) & (r_state == BUSY_F);
  assign w_done_d = (w_complete | w_abort) & (r_state == BUSY_D);

  // --------------------------------------------------------------------------
  // Stall counter: cleared on every grant, counts stalled busy cycles
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_grant_f || w_grant_d) begin
      r_stall_cnt <= '0;
    end else if ((r_state != IDLE) && mem_stall) begin
      r_stall_cnt <= r_stall_cnt + TIMEOUT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registered memory bus and requester responses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_b_en  <= '0;
      mem_w_en  <= 1'b0;
      f_ack     <= 1'b0;
      f_rdata   <= '0;
      f_error   <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_error   <= 1'b0;
    end else begin
      f_ack <= w_done_f;
      d_ack <= w_done_d;

      if (w_grant_f) begin
        // Fetches are always full-word reads.
        mem_addr  <= f_addr;
        mem_wdata <= '0;
        mem_b_en  <= 4'b1111;
        mem_w_en  <= 1'b0;
      end else if (w_grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_b_en  <= d_b_en;
        mem_w_en  <= d_w_en;
      end

      // On abort mem_rdata/mem_error are not valid, so return 0 with error.
      if (w_done_f) begin
        f_rdata <= w_abort ? 32'd0 : mem_rdata;
        f_error <= w_abort ? 1'b1  : mem_error;
      end
      if (w_done_d) begin
        d_rdata <= w_abort ? 32'd0 : mem_rdata;
        d_error <= w_abort ? 1'b1  : mem_error;
      end
    end
  end

  // Decoded from state only, so reset drops it immediately and no mem_*
  // input reaches a mem_* output combinationally.
  assign mem_c_en = (r_state != IDLE);
  assign arb_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rvm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvm_mem_arbiter
// Purpose  : Self-checking bench for rvm_mem_arbiter. A transaction-level
//            reference model predicts every output each cycle; directed
//            scenarios add latency, ordering, timeout, error-hold and
//            reset-mid-transfer checks, followed by a randomized soak.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvm_mem_arbiter;

  localparam int TW           = 4;
  localparam int ABORT_STALLS = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        f_error;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_b_en;
  logic        d_w_en;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_c_en;
  logic [3:0]  mem_b_en;
  logic        mem_w_en;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_stall;
  logic        arb_busy;

  always #5 clk = ~clk;

  rvm_mem_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .f_error   (f_error),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_b_en    (d_b_en),
    .d_w_en    (d_w_en),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_error   (d_error),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_c_en  (mem_c_en),
    .mem_b_en  (mem_b_en),
    .mem_w_en  (mem_w_en),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error),
    .mem_stall (mem_stall),
    .arb_busy  (arb_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the transfer in flight (0 none, 1 fetch, 2 data), the
  // bus it drives, and what each requester has been handed back.
  // --------------------------------------------------------------------------
  int          m_owner;
  int          m_stalls;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_ben;
  logic        m_wen;
  logic        m_f_ack, m_f_err, m_d_ack, m_d_err;
  logic [31:0] m_f_rdata, m_d_rdata;
  logic        m_last_d;

  task automatic model_reset();
    m_owner = 0; m_stalls = 0;
    m_addr = '0; m_wdata = '0; m_ben = '0; m_wen = 1'b0;
    m_f_ack = 1'b0; m_f_err = 1'b0; m_f_rdata = '0;
    m_d_ack = 1'b0; m_d_err = 1'b0; m_d_rdata = '0;
    m_last_d = 1'b1;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit          f_eff, d_eff, nf_ack, nd_ack;
    int          win;
    logic [31:0] rd;
    logic        er;
    nf_ack = 1'b0;
    nd_ack = 1'b0;
    if (m_owner == 0) begin
      f_eff = f_req && !m_f_ack;
      d_eff = d_req && !m_d_ack;
      win = 0;
      if (f_eff && d_eff) begin
`ifdef RVM_MEM_ARB_RR_EN
        win = m_last_d ? 1 : 2;
`else
        win = 2;
`endif
      end else if (f_eff) win = 1;
      else if (d_eff) win = 2;
      if (win == 1) begin
        m_addr = f_addr; m_wdata = '0; m_ben = 4'hF; m_wen = 1'b0;
      end else if (win == 2) begin
        m_addr = d_addr; m_wdata = d_wdata; m_ben = d_b_en; m_wen = d_w_en;
      end
      if (win != 0) begin
        m_owner = win; m_stalls = 0; m_last_d = (win == 2);
      end
    end else if (!mem_stall || (m_stalls + 1 == ABORT_STALLS)) begin
      rd = mem_stall ? 32'd0 : mem_rdata;
      er = mem_stall ? 1'b1 : mem_error;
      if (m_owner == 1) begin
        m_f_rdata = rd; m_f_err = er; nf_ack = 1'b1;
      end else begin
        m_d_rdata = rd; m_d_err = er; nd_ack = 1'b1;
      end
      m_owner = 0;
    end else begin
      m_stalls++;
    end
    m_f_ack = nf_ack;
    m_d_ack = nd_ack;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus policy and observation bookkeeping
  //   requester mode: 0 off, 1 held high, 2 random, 3 one request then off
  //   stall mode    : 0 never, 1 always, 2 random, 3 stall_run busy cycles
  // --------------------------------------------------------------------------
  int          f_mode, d_mode, stall_mode, stall_run;
  bit          rand_mem;
  int          cyc;
  int          f_start, d_start, f_lat, d_lat, cen_cycles;
  logic        prev_f_req, prev_d_req, prev_c_en;
  logic [31:0] grant_log[$];

  task automatic check_outputs();
    check_val("c_en", 64'(mem_c_en), 64'(m_owner != 0));
    check_val("busy", 64'(arb_busy), 64'(m_owner != 0));
    if (m_owner != 0) begin
      check_val("bus_data", 64'({mem_addr, mem_wdata}), 64'({m_addr, m_wdata}));
      check_val("bus_ctl", 64'({mem_b_en, mem_w_en}), 64'({m_ben, m_wen}));
    end
    check_val("f_port", 64'({f_ack, f_error, f_rdata}), 64'({m_f_ack, m_f_err, m_f_rdata}));
    check_val("d_port", 64'({d_ack, d_error, d_rdata}), 64'({m_d_ack, m_d_err, m_d_rdata}));
    if (mem_c_en) cen_cycles++;
    if (mem_c_en && !prev_c_en) grant_log.push_back(mem_addr);
    prev_c_en = mem_c_en;
    if (f_ack && f_start >= 0) begin f_lat = cyc - f_start; f_start = -1; end
    if (d_ack && d_start >= 0) begin d_lat = cyc - d_start; d_start = -1; end
  endtask

  task automatic drive_inputs();
    case (f_mode)
      0: f_req = 1'b0;
      1: f_req = 1'b1;
      2: if (!f_req || m_f_ack) begin
           f_req  = ($urandom_range(0, 1) == 1);
           f_addr = $urandom;
         end
      default: if (m_f_ack) begin f_req = 1'b0; f_mode = 0; end else f_req = 1'b1;
    endcase
    case (d_mode)
      0: d_req = 1'b0;
      1: d_req = 1'b1;
      2: if (!d_req || m_d_ack) begin
           d_req   = ($urandom_range(0, 1) == 1);
           d_addr  = $urandom;
           d_wdata = $urandom;
           d_b_en  = 4'($urandom);
           d_w_en  = 1'($urandom);
         end
      default: if (m_d_ack) begin d_req = 1'b0; d_mode = 0; end else d_req = 1'b1;
    endcase
    case (stall_mode)
      0: mem_stall = 1'b0;
      1: mem_stall = 1'b1;
      2: if (stall_run > 0) begin
           mem_stall = 1'b1; stall_run--;
         end else if ($urandom_range(0, 39) == 0) begin
           mem_stall = 1'b1; stall_run = ABORT_STALLS + 2;
         end else begin
           mem_stall = ($urandom_range(0, 2) == 0);
         end
      default: if (m_owner != 0 && stall_run > 0) begin
                 mem_stall = 1'b1; stall_run--;
               end else begin
                 mem_stall = 1'b0;
               end
    endcase
    if (rand_mem) begin
      mem_rdata = $urandom;
      mem_error = ($urandom_range(0, 7) == 0);
    end
    if (f_req && !prev_f_req) f_start = cyc;
    if (d_req && !prev_d_req) d_start = cyc;
    prev_f_req = f_req;
    prev_d_req = d_req;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_outputs();
    drive_inputs();
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] exp_g[4];
    resetn = 1'b0;
    f_req = 0; f_addr = '0;
    d_req = 0; d_addr = '0; d_wdata = '0; d_b_en = '0; d_w_en = 0;
    mem_rdata = '0; mem_error = 0; mem_stall = 0;
    f_mode = 0; d_mode = 0; stall_mode = 0; stall_run = 0; rand_mem = 0;
    cyc = 0; f_start = -1; d_start = -1; f_lat = -1; d_lat = -1; cen_cycles = 0;
    prev_f_req = 0; prev_d_req = 0; prev_c_en = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_val("rst_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    check_val("rst_ctl", 64'({mem_b_en, mem_w_en, mem_c_en, arb_busy}), 64'd0);
    check_val("rst_ports", 64'({f_ack, f_error, d_ack, d_error}), 64'd0);
    resetn = 1'b1;

    // Single fetch, no stall.
    f_addr = 32'h100; mem_rdata = 32'h13; mem_error = 0;
    f_lat = -1; cen_cycles = 0; f_mode = 3;
    run(6);
    check_val("fetch_lat", 64'(f_lat), 64'd2);
    check_val("fetch_cen", 64'(cen_cycles), 64'd1);
    check_val("fetch_rsp", 64'({f_error, f_rdata}), 64'h13);

    // Store stalled for three cycles.
    d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_b_en = 4'b0011; d_w_en = 1;
    d_lat = -1; cen_cycles = 0; stall_run = 3; stall_mode = 3; d_mode = 3;
    run(9);
    check_val("store_lat", 64'(d_lat), 64'd5);
    check_val("store_cen", 64'(cen_cycles), 64'd4);
    stall_mode = 0;

    // Stall held forever: abort after 2^TW-1 stalled cycles.
    f_addr = 32'h300; f_lat = -1; cen_cycles = 0; stall_mode = 1; f_mode = 3;
    run(22);
    check_val("tmo_lat", 64'(f_lat), 64'(ABORT_STALLS + 1));
    check_val("tmo_cen", 64'(cen_cycles), 64'(ABORT_STALLS));
    check_val("tmo_rsp", 64'({f_error, f_rdata}), 64'h1_0000_0000);
    stall_mode = 0;
    run(2);

    // Error on a load is returned and held until the next d_ack.
    d_addr = 32'h400; d_w_en = 0; d_b_en = 4'hF;
    mem_rdata = 32'hCAFE0001; mem_error = 1; d_mode = 3;
    run(4);
    mem_error = 0;
    run(6);
    check_val("err_hold", 64'(d_error), 64'd1);
    d_mode = 3;
    run(5);
    check_val("err_clear", 64'(d_error), 64'd0);

    // Both requesters held high across several transfers.
    f_addr = 32'h100; d_addr = 32'h2000; d_w_en = 0;
    grant_log.delete();
    f_mode = 1; d_mode = 1;
    run(11);
    f_mode = 0; d_mode = 0;
    run(5);
`ifdef RVM_MEM_ARB_RR_EN
    exp_g = '{32'h100, 32'h2000, 32'h100, 32'h2000};
`else
    exp_g = '{32'h2000, 32'h100, 32'h2000, 32'h100};
`endif
    check_val("grant_cnt", 64'(grant_log.size() >= 4), 64'd1);
    while (grant_log.size() < 4) grant_log.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) check_val($sformatf("grant%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));

    // Randomized soak against the model.
    rand_mem = 1; stall_mode = 2; f_mode = 2; d_mode = 2;
    run(3000);
    f_mode = 0; d_mode = 0; stall_mode = 0; stall_run = 0;
    run(25);
    rand_mem = 0;

    // Reset while a load sits stalled in flight.
    d_addr = 32'h500; d_w_en = 0; stall_mode = 1; d_mode = 3;
    run(4);
    check_val("pre_rst_busy", 64'(mem_c_en), 64'd1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_val("arst_cen", 64'({mem_c_en, arb_busy}), 64'd0);
    check_val("arst_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    check_val("arst_ctl", 64'({mem_b_en, mem_w_en}), 64'd0);
    check_val("arst_f", 64'({f_ack, f_error, f_rdata}), 64'd0);
    check_val("arst_d", 64'({d_ack, d_error, d_rdata}), 64'd0);
    d_mode = 0; d_req = 0; prev_d_req = 0; d_start = -1;
    stall_mode = 0; mem_stall = 0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    f_addr = 32'h600; mem_rdata = 32'h1234; mem_error = 0;
    f_lat = -1; f_mode = 3;
    run(6);
    check_val("post_rst_lat", 64'(f_lat), 64'd2);
    check_val("post_rst_rsp", 64'({f_error, f_rdata}), 64'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
